uart_tx_arb: RTL and testbench



---
 rtl/uart_tx_arb_pkg.sv | 14 +
 rtl/uart_tx_arb_rr_pick.sv | 32 +++
 rtl/uart_tx_arb.sv | 113 +++++++++++
 tb/tb_uart_tx_arb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmitter arbiter: FSM state encoding
// and the default byte width.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } state_t;

  localparam int DW_DEFAULT = 8;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin select: first set request scanning upward from
// i_ptr, wrapping modulo N. Returns one-hot grant and binary index.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx
);

  logic [PW-1:0] w_rot [N];

  // w_rot[k] is the requester sitting k places after the pointer.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign w_rot[gi] = PW'((32'(i_ptr) + 32'(gi)) % 32'(N));
  end

  // Scan from the farthest slot down so the nearest pending one wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[w_rot[k]]) begin
        o_idx = w_rot[k];
        o_gnt = N'(1) << w_rot[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between N byte producers,
// with a start timeout guarding against a transmitter that never goes busy.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int DW        = DW_DEFAULT,
  parameter int START_TMO = 16
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [N-1:0]    Req,
  input  logic [N*DW-1:0] Data,
  output logic [N-1:0]    Gnt,
  output logic [DW-1:0]   Tx_datain,
  output logic            Tx_wrsig,
  input  logic            Tx_busy,
  output logic            Busy,
  output logic            Err
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(START_TMO);

  state_t        r_state, w_state_next;
  logic [PW-1:0] r_ptr, w_ptr_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [DW-1:0] r_datain, w_datain_next;
  logic [N-1:0]  r_gnt, w_gnt_next;
  logic          r_wrsig, w_wrsig_next;
  logic          r_busy, w_busy_next;
  logic          r_err, w_err_next;

  logic [N-1:0]  w_pick_gnt;
  logic [PW-1:0] w_pick_idx;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .i_req (Req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  always_comb begin
    w_state_next  = r_state;
    w_ptr_next    = r_ptr;
    w_cnt_next    = r_cnt;
    w_datain_next = r_datain;
    w_gnt_next    = '0;
    w_wrsig_next  = 1'b0;
    w_err_next    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|Req) begin
          w_datain_next = Data[int'(w_pick_idx) * DW +: DW];
          w_wrsig_next  = 1'b1;
          w_gnt_next    = w_pick_gnt;
          w_ptr_next    = (w_pick_idx == PW'(N - 1)) ? '0 : w_pick_idx + PW'(1);
          w_state_next  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_cnt_next   = '0;
        w_state_next = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        // A missing busy edge drops the byte; the requester already saw Gnt.
        if (Tx_busy) begin
          w_state_next = ST_WAIT_DONE;
        end else if (r_cnt == CW'(START_TMO - 1)) begin
          w_err_next   = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!Tx_busy) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    w_busy_next = (w_state_next != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_datain <= '0;
      r_gnt    <= '0;
      r_wrsig  <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_ptr    <= w_ptr_next;
      r_cnt    <= w_cnt_next;
      r_datain <= w_datain_next;
      r_gnt    <= w_gnt_next;
      r_wrsig  <= w_wrsig_next;
      r_busy   <= w_busy_next;
      r_err    <= w_err_next;
    end
  end

  assign Gnt       = r_gnt;
  assign Tx_datain = r_datain;
  assign Tx_wrsig  = r_wrsig;
  assign Busy      = r_busy;
  assign Err       = r_err;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: table of round-robin vectors plus
// hand-written sequences, with a grant/byte scoreboard and a transmitter model.
module tb_uart_tx_arb;

  localparam int N         = 4;
  localparam int DW        = 8;
  localparam int START_TMO = 16;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [N-1:0]    Req;
  logic [N*DW-1:0] Data;
  logic [N-1:0]    Gnt;
  logic [DW-1:0]   Tx_datain;
  logic            Tx_wrsig;
  logic            Tx_busy;
  logic            Busy;
  logic            Err;

  uart_tx_arb #(.N(N), .DW(DW), .START_TMO(START_TMO)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Req       (Req),
    .Data      (Data),
    .Gnt       (Gnt),
    .Tx_datain (Tx_datain),
    .Tx_wrsig  (Tx_wrsig),
    .Tx_busy   (Tx_busy),
    .Busy      (Busy),
    .Err       (Err)
  );

  always #5 Clk = ~Clk;

  // Transmitter model: busy for busy_len cycles starting the edge after a write.
  int busy_len = 4;
  bit tx_dead  = 1'b0;
  int tx_left;

  always @(posedge Clk) begin
    if (Rst) begin
      Tx_busy <= 1'b0;
      tx_left <= 0;
    end else if (Tx_wrsig && !tx_dead) begin
      Tx_busy <= 1'b1;
      tx_left <= busy_len - 1;
    end else if (tx_left > 0) begin
      tx_left <= tx_left - 1;
    end else begin
      Tx_busy <= 1'b0;
    end
  end

  typedef struct {
    logic [N-1:0]  gnt;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [N-1:0] req;
    int           n;
    logic [15:0]  order;
  } vec_t;

  exp_t exp_q[$];
  int   g_cyc[$];
  int   e_cyc[$];
  vec_t vecs[8];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   prev_err = 1'b0;
  bit   auto_clear = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int idx, input logic [DW-1:0] b);
    exp_t e;
    e.gnt  = N'(1) << idx;
    e.data = b;
    exp_q.push_back(e);
  endtask

  function automatic logic [DW-1:0] vbyte(input int v, input int i);
    return 8'(32'h20 + 16 * v + i);
  endfunction

  // One clock: sample at negedge, score any write, then let requesters react.
  task automatic step();
    exp_t e;
    @(negedge Clk);
    cyc++;
    if (Err) begin
      chk("err_one_cycle", 32'(prev_err), 32'd0);
      e_cyc.push_back(cyc);
    end
    prev_err = Err;
    if (Tx_wrsig) begin
      g_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(Tx_wrsig), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("gnt", 32'(Gnt), 32'(e.gnt));
        chk("tx_datain", 32'(Tx_datain), 32'(e.data));
      end
      $display("grant %b byte %02h at cycle %0d", Gnt, Tx_datain, cyc);
      if (auto_clear) Req = Req & ~Gnt;
    end else begin
      chk("gnt_without_wrsig", 32'(Gnt), 32'd0);
    end
  endtask

  task automatic wait_idle(input int lim);
    bit done = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (exp_q.size() == 0 && !Busy && Req == '0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk("idle_wait", 32'(done), 32'd1);
  endtask

  task automatic wait_tx(input logic lvl, input int lim);
    bit done = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (Tx_busy === lvl) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk("tx_busy_wait", 32'(done), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(Gnt), 32'd0);
    chk({tag, "_wrsig"}, 32'(Tx_wrsig), 32'd0);
    chk({tag, "_datain"}, 32'(Tx_datain), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_err"}, 32'(Err), 32'd0);
  endtask

  initial begin
    vecs[0] = '{4'b1111, 4, 16'h1032};
    vecs[1] = '{4'b0101, 2, 16'h0002};
    vecs[2] = '{4'b1001, 2, 16'h0003};
    vecs[3] = '{4'b0110, 2, 16'h0021};
    vecs[4] = '{4'b1000, 1, 16'h0003};
    vecs[5] = '{4'b1001, 2, 16'h0030};
    vecs[6] = '{4'b0010, 1, 16'h0001};
    vecs[7] = '{4'b0011, 2, 16'h0010};

    // All requesters pending from reset, held continuously.
    Rst = 1'b1;
    Req = 4'b1111;
    for (int i = 0; i < N; i++) Data[i*DW +: DW] = 8'(32'h10 + i);
    step();
    step();
    chk_reset_outputs("reset");
    Rst = 1'b0;
    for (int j = 0; j < 5; j++) push_exp(j % N, 8'(32'h10 + (j % N)));
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    chk("all_pending_done", 32'(exp_q.size()), 32'd0);
    Req = '0;
    wait_idle(100);

    // Single requester: latency, byte hold, and Busy falling after Tx_busy.
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    busy_len = 20;
    auto_clear = 1'b1;
    Data[1*DW +: DW] = 8'hA5;
    Req = 4'b0010;
    push_exp(1, 8'hA5);
    step();
    chk("latency_wrsig", 32'(Tx_wrsig), 32'd1);
    wait_tx(1'b1, 10);
    wait_tx(1'b0, 50);
    chk("busy_before_drop", 32'(Busy), 32'd1);
    chk("datain_held", 32'(Tx_datain), 32'hA5);
    step();
    chk("busy_after_drop", 32'(Busy), 32'd0);
    wait_idle(50);

    // Round-robin table; the pointer carries over between vectors.
    busy_len = 4;
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++) Data[i*DW +: DW] = vbyte(v, i);
      for (int j = 0; j < vecs[v].n; j++) begin
        int idx;
        idx = int'(vecs[v].order[j*4 +: 4]);
        push_exp(idx, vbyte(v, idx));
      end
      Req = vecs[v].req;
      wait_idle(300);
    end

    // Start timeout: transmitter never goes busy.
    tx_dead = 1'b1;
    g_cyc.delete();
    e_cyc.delete();
    for (int i = 0; i < N; i++) Data[i*DW +: DW] = 8'(32'hC0 + i);
    push_exp(2, 8'hC2);
    push_exp(1, 8'hC1);
    Req = 4'b0110;
    wait_idle(200);
    chk("tmo_err_count", 32'(e_cyc.size()), 32'd2);
    chk("tmo_grant_count", 32'(g_cyc.size()), 32'd2);
    if (e_cyc.size() >= 1 && g_cyc.size() >= 2) begin
      chk("tmo_err_delay", 32'(e_cyc[0] - g_cyc[0]), 32'(START_TMO + 1));
      chk("tmo_next_grant", 32'(g_cyc[1] - e_cyc[0]), 32'd1);
    end
    tx_dead = 1'b0;

    // Reset while in WAIT_DONE, then all pending: first grant must be 0.
    busy_len = 20;
    push_exp(2, 8'hC2);
    Req = 4'b0100;
    step();
    wait_tx(1'b1, 10);
    step();
    step();
    step();
    chk("mid_busy_before_reset", 32'(Busy), 32'd1);
    Rst = 1'b1;
    step();
    chk_reset_outputs("mid_reset");
    Rst = 1'b0;
    busy_len = 4;
    for (int i = 0; i < N; i++) Data[i*DW +: DW] = 8'(32'h10 + i);
    for (int j = 0; j < N; j++) push_exp(j, 8'(32'h10 + j));
    Req = 4'b1111;
    wait_idle(300);

    // Early withdrawal: Req[2] pulses during WAIT_DONE and must not be served.
    busy_len = 20;
    push_exp(0, 8'h10);
    Req = 4'b0001;
    step();
    wait_tx(1'b1, 10);
    step();
    step();
    Req[2] = 1'b1;
    step();
    Req[2] = 1'b0;
    wait_idle(100);
    for (int i = 0; i < 5; i++) step();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
